// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and hazard_ctrl: hazard inputs,
// stage enables/flushes, forwarding selects and the data-memory handshake.
interface hazard_ctrl_if;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [2:0] ex_rs;
    logic [2:0] ex_rt;
    logic [2:0] ex_rd;
    logic       ex_mem_read;
    logic       branch_taken;
    logic [2:0] ex_mem_rd;
    logic [2:0] mem_wb_rd;
    logic       ex_mem_reg_write;
    logic       mem_wb_reg_write;
    logic       mem_access;
    logic       dmem_ack;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       dmem_req;
    logic       mem_error;

    // Controller side
    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
               branch_taken, ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
               mem_access, dmem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, dmem_req, mem_error
    );

    // Datapath side
    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
               branch_taken, ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
               mem_access, dmem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, dmem_req, mem_error
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencer: stalls/flushes, EX forwarding and dmem handshake.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_ctrl_if.master        bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]          stall_cycles
`endif
);

    typedef enum logic [1:0] {StRun, StWait, StError} state_e;

    localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       dmem_req, mem_error;
    logic       load_use;

    // Newest producer (EX_MEM) wins over MEM_WB; r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [2:0] src,
        input logic       em_we,
        input logic [2:0] em_rd,
        input logic       mw_we,
        input logic [2:0] mw_rd
    );
        if (em_we && em_rd != 3'd0 && em_rd == src) return 2'b01;
        if (mw_we && mw_rd != 3'd0 && mw_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    assign load_use = bus.ex_mem_read && (bus.ex_rd != 3'd0) &&
                      ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
                       (bus.id_uses_rt && bus.id_rt == bus.ex_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.mem_access && !bus.dmem_ack) begin
                    state_d = StWait;
                    cnt_d   = CntOne;
                end
            end
            StWait: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus.dmem_ack) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == LimitCnt) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StError: ;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_req     = 1'b0;
        mem_error    = (state_q == StError);
        fwd_a = fwd_sel(bus.ex_rs, bus.ex_mem_reg_write, bus.ex_mem_rd,
                        bus.mem_wb_reg_write, bus.mem_wb_rd);
        fwd_b = fwd_sel(bus.ex_rt, bus.ex_mem_reg_write, bus.ex_mem_rd,
                        bus.mem_wb_reg_write, bus.mem_wb_rd);
        if (reset) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en}   = 4'b0000;
            {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b111;
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else begin
            unique case (state_q)
                StRun: begin
                    dmem_req = bus.mem_access;
                    if (bus.mem_access && !bus.dmem_ack) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                        mem_wb_flush = 1'b1;
                    end else if (bus.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                StWait: begin
                    dmem_req = 1'b1;
                    if (!bus.dmem_ack) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                        mem_wb_flush = 1'b1;
                    end
                end
                StError: begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                    mem_wb_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.dmem_req     = dmem_req;
    assign bus.mem_error    = mem_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_en && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
